// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: base opcodes, M-extension funct3 codes, FSM states.
// Optional M-extension engine is enabled by defining ALU_SEQ_MULDIV_EN.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension engine: XLEN shift-add multiply or restoring divide steps on magnitudes,
// sign fix-up applied combinationally on the final step. Only built when ALU_SEQ_MULDIV_EN is defined.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = $clog2(XLEN);

    logic            active_q, active_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;

    logic            sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   sum, rsh, diff;
    logic [XLEN-1:0] step_hi, step_lo, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        sgn_a = funct3_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        sgn_b = funct3_i inside {MD_MULH, MD_DIV, MD_REM};
        a_neg = sgn_a & op_a_i[XLEN-1];
        b_neg = sgn_b & op_b_i[XLEN-1];
        mag_a = a_neg ? ('0 - op_a_i) : op_a_i;
        mag_b = b_neg ? ('0 - op_b_i) : op_b_i;
    end

    // Multiply: {hi,lo} shifts right with the multiplier in lo. Divide: {hi,lo} shifts left, quotient bits enter lo.
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rsh  = {hi_q, lo_q[XLEN-1]};
        diff = rsh - {1'b0, opb_q};
        if (f3_q[2]) begin
            if (!diff[XLEN]) begin
                step_hi = diff[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = rsh[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? ('0 - prod) : prod;
        quo_fix  = neg_q ? ('0 - step_lo) : step_lo;
        rem_fix  = neg_q ? ('0 - step_hi) : step_hi;
        case (f3_q)
            MD_MUL:                       result_o = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result_o = quo_fix;
            default:                      result_o = rem_fix;
        endcase
        done_o = active_q & (cnt_q == '0);
    end

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        if (abort_i) begin
            active_d = 1'b0;
        end else if (start_i) begin
            active_d = 1'b1;
            cnt_d    = CW'(XLEN - 1);
            f3_d     = funct3_i;
            hi_d     = '0;
            if (funct3_i[2]) begin
                lo_d  = mag_a;
                opb_d = mag_b;
                neg_d = funct3_i[1] ? a_neg : (a_neg ^ b_neg);
            end else begin
                lo_d  = mag_b;
                opb_d = mag_a;
                neg_d = a_neg ^ b_neg;
            end
        end else if (active_q) begin
            hi_d = step_hi;
            lo_d = step_lo;
            if (cnt_q == '0) active_d = 1'b0;
            else             cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered integer ALU with masked shifts. Defining ALU_SEQ_MULDIV_EN adds the
// iterative M-extension engine; otherwise M ops return 0 with single-cycle latency.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [XLEN-1:0] op_1_in,
    input  logic [XLEN-1:0] op_2_in,
    input  logic [3:0]      opcode_in,
    input  logic            m_in,
    input  logic            flush_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] result_out,
    output logic            busy_out
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] base_res, quick_res, eng_res;
    logic [SHW-1:0]  shamt;
    logic            accept, go_iter, eng_done;

    assign shamt  = op_2_in[SHW-1:0];
    assign accept = valid_in & ready_out;

    always_comb begin
        case (opcode_in)
            ALU_ADD:  base_res = op_1_in + op_2_in;
            ALU_SUB:  base_res = op_1_in - op_2_in;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(op_1_in) < $signed(op_2_in))};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (op_1_in < op_2_in)};
            ALU_AND:  base_res = op_1_in & op_2_in;
            ALU_OR:   base_res = op_1_in | op_2_in;
            ALU_XOR:  base_res = op_1_in ^ op_2_in;
            ALU_SLL:  base_res = op_1_in << shamt;
            ALU_SRL:  base_res = op_1_in >> shamt;
            ALU_SRA:  base_res = $unsigned($signed(op_1_in) >>> shamt);
            default:  base_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic is_div, div_zero, div_ovf;

    // Divide-by-zero and MIN/-1 never reach the engine; they complete on the single-cycle path.
    assign is_div   = m_in & opcode_in[2];
    assign div_zero = is_div & (op_2_in == '0);
    assign div_ovf  = is_div & ~opcode_in[0] & (op_1_in == XMIN) & (op_2_in == '1);
    assign go_iter  = m_in & ~div_zero & ~div_ovf;

    always_comb begin
        quick_res = base_res;
        if (div_zero)     quick_res = opcode_in[1] ? op_1_in : '1;
        else if (div_ovf) quick_res = opcode_in[1] ? '0 : XMIN;
    end

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk_i    (clk_in),
        .rst_ni   (rst_n_in),
        .start_i  (accept & go_iter),
        .abort_i  (flush_in),
        .funct3_i (opcode_in[2:0]),
        .op_a_i   (op_1_in),
        .op_b_i   (op_2_in),
        .done_o   (eng_done),
        .result_o (eng_res)
    );
`else
    assign go_iter   = 1'b0;
    assign eng_done  = 1'b0;
    assign eng_res   = '0;
    assign quick_res = m_in ? '0 : base_res;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (go_iter) begin
                        state_d = BUSY;
                    end else begin
                        state_d  = DONE;
                        result_d = quick_res;
                    end
                end else if (ready_in) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (eng_done) begin
                    state_d  = DONE;
                    result_d = eng_res;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_in) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_comb begin
        valid_out  = (state_q == DONE);
        ready_out  = ~flush_in & ((state_q == IDLE) | ((state_q == DONE) & ready_in));
`ifdef ALU_SEQ_MULDIV_EN
        busy_out   = (state_q == BUSY);
`else
        busy_out   = 1'b0;
`endif
        result_out = result_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq against a behavioural model; adapts to ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

    localparam int unsigned XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        valid_in, ready_out, m_in, flush_in, valid_out, ready_in, busy_out;
    logic [31:0] op_1_in, op_2_in, result_out;
    logic [3:0]  opcode_in;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk_in = ~clk_in;

    alu_seq #(
        .XLEN (XLEN)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .op_1_in    (op_1_in),
        .op_2_in    (op_2_in),
        .opcode_in  (opcode_in),
        .m_in       (m_in),
        .flush_in   (flush_in),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .result_out (result_out),
        .busy_out   (busy_out)
    );

    function automatic logic [31:0] ref_base(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] ext;
        sh  = b % 32;
        ext = {{32{a[31]}}, a} >> sh;
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            4'b0001: return a << sh;
            4'b0101: return a >> sh;
            4'b1101: return ext[31:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        q   = 0;
        p   = '0;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic expect_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] exp, output int lat);
        bit special;
        special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp = MD_EN ? ref_m(f3, a, b) : 32'd0;
        lat = (MD_EN && !special) ? XLEN + 1 : 1;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, consumer ready; lat counts 1 for a result visible right after the accept edge.
    task automatic do_op(input logic m, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n);
        int guard;
        @(negedge clk_in);
        guard = 0;
        while (!ready_out && guard < 200) begin
            @(negedge clk_in);
            guard++;
        end
        valid_in = 1'b1; m_in = m; opcode_in = op; op_1_in = a; op_2_in = b; ready_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0; op_1_in = $urandom; op_2_in = $urandom; opcode_in = 4'($urandom); m_in = 1'($urandom);
        lat = 1;
        busy_n = 0;
        while (!valid_out && lat < 200) begin
            if (busy_out) busy_n++;
            @(posedge clk_in); #1;
            lat++;
        end
        res = result_out;
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1; flush_in = 1'b0;
        m_in = 1'b0; opcode_in = '0; op_1_in = '0; op_2_in = '0;
        repeat (2) @(negedge clk_in);
        total_cnt++;
        if ({valid_out, busy_out, result_out} !== 34'd0)
            $display("FAIL reset_outputs: got valid=%b busy=%b result=%h, want all 0", valid_out, busy_out, result_out);
        else pass_cnt++;
        total_cnt++;
        if (ready_out !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_out);
        else pass_cnt++;
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_sra_mask();
        logic [31:0] res;
        int lat, bn;
        do_op(1'b0, 4'b1101, 32'h8000_0000, 32'h0000_0024, res, lat, bn);
        total_cnt++;
        if (res !== 32'hF800_0000) $display("FAIL sra_mask: got %h want F8000000", res);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 1) $display("FAIL sra_latency: got %0d want 1", lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        localparam int N = 13;
        logic [3:0]  codes[10] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
                                   4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};
        logic [3:0]  ops[N];
        logic [31:0] as[N], bs[N], exps[N];
        ops[0] = 4'b0000; as[0] = 5; bs[0] = 7;            exps[0] = 32'd12;
        ops[1] = 4'b1000; as[1] = 5; bs[1] = 7;            exps[1] = 32'hFFFF_FFFE;
        ops[2] = 4'b0011; as[2] = 1; bs[2] = 32'hFFFF_FFFF; exps[2] = 32'd1;
        for (int i = 3; i < N; i++) begin
            ops[i] = codes[$urandom_range(0, 9)]; as[i] = pick_op(); bs[i] = pick_op();
            exps[i] = ref_base(ops[i], as[i], bs[i]);
        end
        ready_in = 1'b1;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk_in);
            if (i > 0) begin
                total_cnt++;
                if (valid_out !== 1'b1 || result_out !== exps[i-1])
                    $display("FAIL b2b_%0d: got valid=%b result=%h want valid=1 result=%h", i - 1, valid_out, result_out, exps[i-1]);
                else pass_cnt++;
            end
            if (i < N) begin
                valid_in = 1'b1; m_in = 1'b0; opcode_in = ops[i]; op_1_in = as[i]; op_2_in = bs[i];
            end else begin
                valid_in = 1'b0;
            end
        end
        @(negedge clk_in);
        total_cnt++;
        if (valid_out !== 1'b0) $display("FAIL b2b_drain: got valid=%b want 0", valid_out);
        else pass_cnt++;
    endtask

    task automatic test_random_base();
        logic [3:0]  codes[10] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
                                   4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};
        logic [3:0]  op;
        logic [31:0] a, b, res, exp;
        int lat, bn;
        for (int i = 0; i < 30; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : codes[$urandom_range(0, 9)];
            a = pick_op(); b = pick_op();
            exp = ref_base(op, a, b);
            do_op(1'b0, op, a, b, res, lat, bn);
            total_cnt++;
            if (res !== exp || lat !== 1)
                $display("FAIL base_op%h: a=%h b=%h got %h lat %0d want %h lat 1", op, a, b, res, lat, exp);
            else pass_cnt++;
        end
    endtask

    task automatic run_m_case(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res, exp;
        int lat, bn, elat;
        expect_m(f3, a, b, exp, elat);
        do_op(1'b1, {1'b0, f3}, a, b, res, lat, bn);
        total_cnt++;
        if (res !== exp) $display("FAIL %s_result: f3=%0d a=%h b=%h got %h want %h", name, f3, a, b, res, exp);
        else pass_cnt++;
        total_cnt++;
        if (lat !== elat || bn !== elat - 1)
            $display("FAIL %s_timing: got latency %0d busy %0d want latency %0d busy %0d", name, lat, bn, elat, elat - 1);
        else pass_cnt++;
    endtask

    task automatic test_muldiv();
        run_m_case("mulh_neg1x2", 3'd1, 32'hFFFF_FFFF, 32'd2);
        run_m_case("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2);
        run_m_case("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2);
        run_m_case("mul_3x4",     3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 16; i++)
            run_m_case("m_random", 3'($urandom), pick_op(), pick_op());
    endtask

    task automatic test_div_special();
        run_m_case("divu_by0",  3'd5, 32'd10, 32'd0);
        run_m_case("rem_by0",   3'd6, 32'd10, 32'd0);
        run_m_case("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_m_case("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_m_case("remu_by0",  3'd7, 32'h1234_5678, 32'd0);
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp;
        @(negedge clk_in);
        a = $urandom; b = $urandom; exp = a ^ b;
        valid_in = 1'b1; m_in = 1'b0; opcode_in = 4'b0100; op_1_in = a; op_2_in = b; ready_in = 1'b0;
        @(posedge clk_in); #1;
        opcode_in = 4'b0000; op_1_in = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            total_cnt++;
            if (valid_out !== 1'b1 || result_out !== exp || ready_out !== 1'b0)
                $display("FAIL hold_%0d: got valid=%b ready=%b result=%h want valid=1 ready=0 result=%h",
                         i, valid_out, ready_out, result_out, exp);
            else pass_cnt++;
        end
        valid_in = 1'b0; ready_in = 1'b1;
        @(posedge clk_in); #1;
        total_cnt++;
        if (valid_out !== 1'b0) $display("FAIL hold_release: got valid=%b want 0", valid_out);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, bn;
        bit seen;
        @(negedge clk_in);
        valid_in = 1'b1; m_in = MD_EN; opcode_in = MD_EN ? 4'b0101 : 4'b0110;
        op_1_in = $urandom; op_2_in = $urandom | 32'd1;
        ready_in = !MD_EN;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        if (MD_EN) repeat (9) @(posedge clk_in);
        @(negedge clk_in);
        flush_in = 1'b1; valid_in = 1'b1; m_in = 1'b0; opcode_in = 4'b0000; op_1_in = 1; op_2_in = 1;
        #1;
        total_cnt++;
        if (ready_out !== 1'b0 || (busy_out | valid_out) !== 1'b1)
            $display("FAIL flush_pre: got ready=%b busy=%b valid=%b want ready=0 and op in flight", ready_out, busy_out, valid_out);
        else pass_cnt++;
        @(posedge clk_in); #1;
        total_cnt++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0)
            $display("FAIL flush_idle: got valid=%b busy=%b want 0 0", valid_out, busy_out);
        else pass_cnt++;
        @(negedge clk_in);
        flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            if (valid_out) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL flush_discard: got valid seen=%b want 0", seen);
        else pass_cnt++;
        do_op(1'b0, 4'b0000, 32'd40, 32'd2, res, lat, bn);
        total_cnt++;
        if (res !== 32'd42 || lat !== 1) $display("FAIL flush_after: got %h lat %0d want 0000002a lat 1", res, lat);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int lat, bn;
        do_op(1'b0, 4'b0000, 32'd100, 32'd23, res, lat, bn);
        @(negedge clk_in);
        valid_in = 1'b1; m_in = 1'b1; opcode_in = 4'b0000; op_1_in = $urandom; op_2_in = $urandom; ready_in = 1'b0;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        total_cnt++;
        if ((busy_out | valid_out) !== 1'b1 || result_out !== (MD_EN ? 32'd123 : 32'd0))
            $display("FAIL pre_reset: got busy=%b valid=%b result=%h", busy_out, valid_out, result_out);
        else pass_cnt++;
        #1;
        rst_n_in = 1'b0;
        #1;
        total_cnt++;
        if ({valid_out, busy_out, result_out} !== 34'd0)
            $display("FAIL async_reset: got valid=%b busy=%b result=%h want all 0", valid_out, busy_out, result_out);
        else pass_cnt++;
        @(negedge clk_in);
        rst_n_in = 1'b1; ready_in = 1'b1;
        do_op(1'b0, 4'b0000, 32'hFFFF_FFFF, 32'd3, res, lat, bn);
        total_cnt++;
        if (res !== 32'd2 || lat !== 1) $display("FAIL add_after_reset: got %h lat %0d want 00000002 lat 1", res, lat);
        else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sra_mask();
        test_back_to_back();
        test_random_base();
        test_muldiv();
        test_div_special();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle integer ALU in the execute stage. It registers every result behind a valid/ready interface and masks shift amounts to log2(XLEN) bits. Under a compile option it adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) using an iterative shift-add/restoring engine. The execute stage stalls on `ready_out`/`valid_out` instead of assuming one-cycle results.

## Interface
- `XLEN`, default 32: operand/result width; power of two, 8..64.
- `SHW`, default $clog2(XLEN): shift-amount bits used from `op_2_in`.
- `clk_in` in 1: clock, rising edge.
- `rst_n_in` in 1: reset. One clock; reset is asynchronous and active-low.
- `valid_in` in 1: operation offered.
- `ready_out` out 1: block can accept this cycle.
- `op_1_in` in XLEN: operand 1 (rs1).
- `op_2_in` in XLEN: operand 2 (rs2/imm).
- `opcode_in` in 4: base op, {funct7[5], funct3}.
- `m_in` in 1: selects M-extension op; funct3 = `opcode_in[2:0]`.
- `flush_in` in 1: synchronous abort.
- `valid_out` out 1: result held.
- `ready_in` in 1: consumer takes result.
- `result_out` out XLEN: result, stable while `valid_out`=1.
- `busy_out` out 1: iterative op in progress.

## Operation
Base opcodes:
- ADD 0000, SUB 1000.
- SLT 0010, signed; SLTU 0011.
- AND 0111, OR 0110, XOR 0100.
- SLL 0001, SRL 0101, SRA 1101; shift amount is `op_2_in[SHW-1:0]`.
- Any other code returns 0.

M ops, by funct3:
- 000 MUL: low XLEN bits.
- 001 MULH: signed×signed, high XLEN bits.
- 010 MULHSU: signed×unsigned, high XLEN bits.
- 011 MULHU: unsigned×unsigned, high XLEN bits.
- 100 DIV, 101 DIVU, 110 REM, 111 REMU.

Multiplication and division run on magnitudes; the engine applies the sign fix-up in the final cycle. Signed results follow RISC-V truncation semantics (quotient rounds toward zero, remainder takes the dividend's sign).

Special cases, detected at acceptance and taking the 1-cycle path:
- Divide by zero: quotient = all ones, remainder = `op_1_in`.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.

FSM:
- **IDLE**: `ready_out`=1. On accept, a base op or special case goes to DONE; an M op goes to BUSY with counter = XLEN-1.
- **BUSY**: one partial-product/remainder step per cycle; counter decrements. At counter 0, go to DONE.
- **DONE**: `valid_out`=1. On `ready_in`, go to IDLE, or stay in DONE if a new base op is accepted the same cycle. `ready_out` = `ready_in`, so back-to-back base ops sustain one per cycle. A new M op goes to BUSY.

Flush: `flush_in`=1 forces IDLE at the next edge regardless of state and discards any result. An op offered in the same cycle is not accepted (`ready_out`=0 while `flush_in`=1).

Reset values: state IDLE, `valid_out`=0, `busy_out`=0, `result_out`=0, counter 0. Reset asserted mid-BUSY aborts immediately and asynchronously.

## Timing
- Acceptance is `valid_in & ready_out` at a rising edge.
- Base op or special case: `valid_out` high the cycle after acceptance (latency 1).
- Multiply/divide: `valid_out` high XLEN+1 cycles after acceptance (33 for XLEN=32).
- `busy_out`=1 exactly in BUSY.
- `result_out` is registered and changes only on entry to DONE.
- Consumer backpressure holds DONE indefinitely with the result unchanged.
- Inputs are sampled only at acceptance; operands may change freely afterwards.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: M-extension engine built as above.
- `ALU_SEQ_MULDIV_EN` undefined: no engine, BUSY unreachable, `busy_out` tied 0. Any op with `m_in`=1 returns 0 with latency 1.

## Structure
- Package `alu_pkg` holds:
  - base opcode localparams (`ALU_ADD` … `ALU_SRA`);
  - M funct3 localparams;
  - the FSM state enum {IDLE, BUSY, DONE}.
- Sub-module `alu_muldiv_iter` (start/done, XLEN-parameterised) contains the counter, accumulator/remainder registers and sign fix-up. It is instantiated only under `ALU_SEQ_MULDIV_EN`.
- Base combinational datapath and FSM live in `alu_seq`.

## Test plan
- **SRA, shift masking:** XLEN=32, SRA, op1=0x8000_0000, op2=0x0000_0024. Expect 0xF800_0000, since the shift is masked to 4. `valid_out` one cycle after acceptance.
- **Back-to-back base ops:** ADD 5+7, SUB 5-7, SLTU 1<0xFFFF_FFFF with `ready_in`=1 throughout. Expect 12, 0xFFFF_FFFE, 1 on consecutive cycles.
- **Signed multiply and divide:** MULH with op1=0xFFFF_FFFF (-1), op2=2. Expect 0xFFFF_FFFF after 33 cycles with `busy_out` high for 32 cycles. DIV -7/2 gives 0xFFFF_FFFD (-3); REM -7/2 gives 0xFFFF_FFFF (-1).
- **Division special cases:** DIVU 10/0 gives 0xFFFF_FFFF; REM 10/0 gives 10; DIV 0x8000_0000 / -1 gives 0x8000_0000. All have latency 1.
- **Backpressure and flush:**
  - Hold `ready_in`=0 for 5 cycles in DONE: `result_out` stable and `ready_out`=0.
  - Assert `flush_in` at cycle 10 of a DIVU: next cycle IDLE, `valid_out` never asserts.
- **Reset and macro-off build:**
  - Drop `rst_n_in` mid-BUSY: outputs go to 0 immediately, and a following ADD works.
  - Build without `ALU_SEQ_MULDIV_EN`: MUL 3×4 returns 0 at latency 1.
